bin_writer: RTL and testbench

Writer side of the binary-image frame buffer: thresholds an incoming grayscale pixel stream to 1 bit per pixel and writes it row-major into the single-bit BRAM that the locate stage reads. It measures frame width/height and hands the completed frame to the locate stage with the dmn_en/dmn_end level handshake. It then holds off new frames until the locate stage releases the buffer.

---
 rtl/bin_writer.sv | 103 ++++++++++
 tb/tb_bin_writer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_writer.sv
// bin_writer: thresholds a grayscale pixel stream to 1 bpp, writes it row-major to BRAM
// and hands finished frames to the locate stage. Option macro: BIN_WRITER_INVERT_EN.
module bin_writer #(
  parameter int ADDR_WIDTH_2   = 16,
  parameter int PIX_WIDTH      = 8,
  parameter int THRESH_DEFAULT = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pix_valid,
  input  logic [PIX_WIDTH-1:0]    pix_data,
  input  logic                    pix_sof,
  input  logic                    pix_eol,
  input  logic                    pix_eof,
  input  logic                    thresh_wr,
  input  logic [PIX_WIDTH-1:0]    thresh_in,
  output logic                    wr_en,
  output logic [ADDR_WIDTH_2-1:0] wr_addr,
  output logic                    wr_data,
  output logic [31:0]             width,
  output logic [31:0]             height,
  output logic                    dmn_en,
  input  logic                    dmn_end,
  output logic                    err_line,
  output logic                    err_ovf,
  output logic [7:0]              drop_cnt
);
  localparam logic [ADDR_WIDTH_2-1:0] LAST = '1;
  typedef enum logic [1:0] {IDLE, WRITE, HANDOFF, RELEASE} state_t;
  state_t r_state, w_next;
  logic [PIX_WIDTH-1:0]    r_thresh;
  logic [ADDR_WIDTH_2-1:0] r_addr;
  logic                    r_full;
  logic [31:0]             r_col;
  logic                    w_acc, w_restart, w_clr, w_eol, w_full, w_wr, w_bit, w_busy;
  logic [ADDR_WIDTH_2-1:0] w_addr;
  logic [31:0]             w_col, w_width, w_height;
  assign w_acc     = pix_valid && (r_state == WRITE || (r_state == IDLE && pix_sof));
  assign w_restart = w_acc && pix_sof;
  assign w_clr     = w_acc && r_state == IDLE;
  assign w_eol     = pix_eol || pix_eof;
  assign w_addr    = w_restart ? '0 : r_addr;
  assign w_full    = !w_restart && r_full;
  assign w_wr      = w_acc && !w_full;
  assign w_col     = (w_restart ? 32'd0 : r_col) + 32'd1;
  assign w_width   = w_restart ? 32'd0 : width;
  assign w_height  = w_restart ? 32'd0 : height;
  assign w_busy    = r_state == HANDOFF || r_state == RELEASE;
`ifdef BIN_WRITER_INVERT_EN
  assign w_bit = pix_data < r_thresh;
`else
  assign w_bit = pix_data >= r_thresh;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? (pix_eof ? HANDOFF : WRITE) : IDLE;
      WRITE:   w_next = (pix_valid && pix_eof) ? HANDOFF : WRITE;
      HANDOFF: w_next = dmn_end ? RELEASE : HANDOFF;
      RELEASE: w_next = dmn_end ? RELEASE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_thresh <= PIX_WIDTH'(THRESH_DEFAULT);
      r_addr   <= '0;
      r_full   <= 1'b0;
      r_col    <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 1'b0;
      width    <= '0;
      height   <= '0;
      dmn_en   <= 1'b0;
      err_line <= 1'b0;
      err_ovf  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (thresh_wr) r_thresh <= thresh_in;
      wr_en  <= w_wr;
      dmn_en <= r_state == HANDOFF && !dmn_end;
      if (w_wr) begin
        wr_addr <= w_addr;
        wr_data <= w_bit;
        // the final address is held rather than wrapped; r_full gates later beats
        r_addr  <= (w_addr == LAST) ? w_addr : w_addr + 1'b1;
        r_full  <= w_addr == LAST;
      end
      if (w_acc) begin
        r_col  <= w_eol ? 32'd0 : w_col;
        width  <= (w_eol && w_height == 32'd0) ? w_col : w_width;
        height <= w_eol ? w_height + 32'd1 : w_height;
      end
      err_line <= (err_line && !w_clr) || (w_acc && w_eol && w_height != 32'd0 && w_col != w_width);
      err_ovf  <= (err_ovf && !w_clr) || (w_acc && w_full);
      if (w_busy && pix_valid && pix_sof && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_bin_writer.sv
// tb_bin_writer: table-driven and sequence checks of bin_writer with a write scoreboard,
// using a 16-pixel buffer so overflow is reachable.
module tb_bin_writer;
  localparam int AW = 4;
`ifdef BIN_WRITER_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif
  logic clk = 0, rst_n = 0, pix_valid = 0, pix_sof = 0, pix_eol = 0, pix_eof = 0;
  logic thresh_wr = 0, dmn_end = 0;
  logic [7:0] pix_data = 0, thresh_in = 0;
  logic wr_en, wr_data, dmn_en, err_line, err_ovf;
  logic [AW-1:0] wr_addr;
  logic [31:0] width, height;
  logic [7:0] drop_cnt;
  int total = 0, bad = 0;
  logic [7:0] m_thr = 8'd128;
  typedef struct {logic [AW-1:0] a; logic d;} wr_t;
  typedef struct {logic [7:0] d; logic sof, eol, eof, exp;} vec_t;
  wr_t q[$];
  wr_t mon_e;
  vec_t tbl[12];

  always #5 clk = ~clk;

  bin_writer #(.ADDR_WIDTH_2(AW)) dut (
    .clk(clk), .rst_n(rst_n), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .thresh_wr(thresh_wr), .thresh_in(thresh_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .width(width), .height(height), .dmn_en(dmn_en), .dmn_end(dmn_end),
    .err_line(err_line), .err_ovf(err_ovf), .drop_cnt(drop_cnt));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n && wr_en) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_write: got addr %0d want no write", wr_addr);
      end else begin
        mon_e = q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(mon_e.a));
        check("wr_data", 32'(wr_data), 32'(mon_e.d));
      end
    end

  function automatic logic eb(input logic [7:0] d);
    return (d >= m_thr) ^ INV;
  endfunction

  task automatic drive(input logic [7:0] d, input logic s, input logic l, input logic f,
                       input logic w, input logic [AW-1:0] a, input logic b);
    wr_t e;
    pix_valid = 1; pix_data = d; pix_sof = s; pix_eol = l; pix_eof = f;
    if (w) begin
      e.a = a;
      e.d = b;
      q.push_back(e);
    end
    @(posedge clk); #1;
    pix_valid = 0; pix_sof = 0; pix_eol = 0; pix_eof = 0;
  endtask

  task automatic handshake();
    int n = 0;
    while (!dmn_en && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("dmn_en_rise", 32'(dmn_en), 32'd1);
    dmn_end = 1;
    @(posedge clk); #1;
    check("dmn_en_drop", 32'(dmn_en), 32'd0);
    dmn_end = 0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values();
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_width", width, 0);
    check("rst_height", height, 0);
    check("rst_dmn_en", 32'(dmn_en), 0);
    check("rst_err_line", 32'(err_line), 0);
    check("rst_err_ovf", 32'(err_ovf), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
  endtask

  initial begin
    for (int i = 0; i < 12; i++) begin
      tbl[i].d   = (i % 2) ? 8'd200 : 8'd0;
      tbl[i].sof = i == 0;
      tbl[i].eol = i % 4 == 3;
      tbl[i].eof = i == 11;
      tbl[i].exp = (i % 2) == 1;
    end
    #12;
    check_reset_values();
    rst_n = 1;
    @(posedge clk); #1;

    // 4x3 frame from the table
    for (int i = 0; i < 12; i++)
      drive(tbl[i].d, tbl[i].sof, tbl[i].eol, tbl[i].eof, 1'b1, AW'(i), tbl[i].exp ^ INV);
    check("dmn_en_early", 32'(dmn_en), 0);
    @(posedge clk); #1;
    check("dmn_en_2cyc", 32'(dmn_en), 1);
    check("width_4x3", width, 4);
    check("height_4x3", height, 3);

    // handshake held off; one sof dropped while busy
    for (int i = 0; i < 100; i++) begin
      if (i == 50) drive(8'd200, 1, 0, 0, 0, 0, 0);
      else begin
        @(posedge clk); #1;
      end
    end
    check("dmn_en_hold", 32'(dmn_en), 1);
    check("drop_cnt_1", 32'(drop_cnt), 1);
    dmn_end = 1;
    @(posedge clk); #1;
    check("dmn_en_release", 32'(dmn_en), 0);
    drive(8'd200, 0, 1, 1, 0, 0, 0);
    dmn_end = 0;
    @(posedge clk); #1;
    check("drop_cnt_keep", 32'(drop_cnt), 1);
    check("width_stable", width, 4);

    // line lengths 4,3,4
    for (int k = 0; k < 11; k++)
      drive(8'd200, k == 0, k == 3 || k == 6, k == 10, 1'b1, AW'(k), eb(8'd200));
    check("err_line_set", 32'(err_line), 1);
    check("width_443", width, 4);
    check("height_443", height, 3);
    check("err_ovf_443", 32'(err_ovf), 0);
    handshake();

    // 5x4 frame into 16 pixels of storage
    for (int i = 0; i < 20; i++)
      drive(8'(i * 13), i == 0, i % 5 == 4, i == 19, i < 16, AW'(i), eb(8'(i * 13)));
    check("err_ovf_set", 32'(err_ovf), 1);
    check("err_line_clr", 32'(err_line), 0);
    check("height_ovf", height, 4);
    check("width_ovf", width, 5);
    check("wr_addr_hold", 32'(wr_addr), 15);
    handshake();

    // restart mid-frame after 7 beats, then a 2x2 frame
    drive(8'd140, 1, 0, 0, 1, 0, eb(8'd140));
    check("err_ovf_clr", 32'(err_ovf), 0);
    for (int k = 1; k < 7; k++)
      drive(8'(k * 40), 0, k == 2, 0, 1, AW'(k), eb(8'(k * 40)));
    for (int k = 0; k < 4; k++)
      drive(8'(k * 70), k == 0, k == 1, k == 3, 1, AW'(k), eb(8'(k * 70)));
    check("width_2x2", width, 2);
    check("height_2x2", height, 2);
    handshake();

    // threshold write, then a single-pixel frame
    thresh_wr = 1; thresh_in = 8'd50;
    @(posedge clk); #1;
    thresh_wr = 0;
    m_thr = 8'd50;
    drive(8'd60, 1, 1, 1, 1, 0, eb(8'd60));
    check("width_1px", width, 1);
    check("height_1px", height, 1);
    handshake();

    // reset mid-frame
    drive(8'd10, 1, 0, 0, 1, 0, eb(8'd10));
    drive(8'd220, 0, 1, 0, 1, 1, eb(8'd220));
    drive(8'd30, 0, 0, 0, 1, 2, eb(8'd30));
    check("width_pre_rst", width, 2);
    check("height_pre_rst", height, 1);
    @(negedge clk); #1;
    rst_n = 0;
    #1;
    check_reset_values();
    m_thr = 8'd128;
    #2 rst_n = 1;
    @(posedge clk); #1;
    drive(8'd100, 1, 1, 1, 1, 0, eb(8'd100));
    handshake();

    @(negedge clk); #1;
    check("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
